// File: rtl/clock_div_prog.sv
// ============================================================================
// Module   : clock_div_prog
// Brief    : Runtime-programmable clock divider with duty control and wrap tick.
//            Optional period counter output enabled by CLKDIV_PERIOD_CNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module clock_div_prog #(
    parameter int unsigned WIDTH      = 28,
    parameter int unsigned DEF_PERIOD = 25000000,
    parameter int unsigned DEF_HIGH   = 12500000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [WIDTH-1:0] cfg_period,
    input  logic [WIDTH-1:0] cfg_high,
    output logic             out_clk,
    output logic             tick
`ifdef CLKDIV_PERIOD_CNT_EN
    ,
    output logic [15:0]      period_cnt
`endif
);

    localparam logic [WIDTH-1:0] C_ZERO    = '0;
    localparam logic [WIDTH-1:0] C_ONE     = WIDTH'(1);
    localparam logic [WIDTH-1:0] C_TWO     = WIDTH'(2);
    localparam logic [WIDTH-1:0] C_DEF_PER = WIDTH'(DEF_PERIOD);
    localparam logic [WIDTH-1:0] C_DEF_HI  = WIDTH'(DEF_HIGH);

    logic [WIDTH-1:0] r_cnt;
    logic [WIDTH-1:0] r_per;
    logic [WIDTH-1:0] r_high;
    logic [WIDTH-1:0] r_pend_per;
    logic [WIDTH-1:0] r_pend_high;
    logic             r_pending;
    logic             r_out_clk;
    logic             r_tick;

    logic             w_wrap;
    logic             w_capture;
    logic             w_apply;
    logic [WIDTH-1:0] w_clamp_per;
    logic [WIDTH-1:0] w_clamp_high;

    // Only one config may be in flight; a new one is refused until it applies.
    assign cfg_ready = ~r_pending;
    assign w_capture = cfg_valid & ~r_pending;
    assign w_wrap    = en & (r_cnt == (r_per - C_ONE));
    assign w_apply   = r_pending & (~en | w_wrap);

    // Period is clamped first so the high-time clamp sees the final period.
    assign w_clamp_per  = (cfg_period < C_TWO) ? C_TWO : cfg_period;
    assign w_clamp_high = (cfg_high >= w_clamp_per) ? (w_clamp_per - C_ONE) : cfg_high;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt       <= C_ZERO;
            r_per       <= C_DEF_PER;
            r_high      <= C_DEF_HI;
            r_pend_per  <= C_DEF_PER;
            r_pend_high <= C_DEF_HI;
            r_pending   <= 1'b0;
            r_out_clk   <= 1'b0;
            r_tick      <= 1'b0;
        end else begin
            if (w_capture) begin
                r_pend_per  <= w_clamp_per;
                r_pend_high <= w_clamp_high;
            end
            r_pending <= (r_pending & ~w_apply) | w_capture;

            if (!en) begin
                r_cnt     <= C_ZERO;
                r_out_clk <= 1'b0;
                r_tick    <= 1'b0;
            end else begin
                r_out_clk <= (r_cnt < r_high);
                r_tick    <= w_wrap;
                r_cnt     <= w_wrap ? C_ZERO : (r_cnt + C_ONE);
            end

            // Swapping on the wrap edge lets the running period finish on old values.
            if (w_apply) begin
                r_per  <= r_pend_per;
                r_high <= r_pend_high;
            end
        end
    end

    assign out_clk = r_out_clk;
    assign tick    = r_tick;

`ifdef CLKDIV_PERIOD_CNT_EN
    logic [15:0] r_period_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_period_cnt <= 16'd0;
        end else if (w_wrap) begin
            r_period_cnt <= r_period_cnt + 16'd1;
        end
    end

    assign period_cnt = r_period_cnt;
`else
    // No period counter in this build.
`endif

endmodule

`default_nettype wire
